// File: rtl/inference_drain.sv
// ---------------------------------------------------------------------------
// inference_drain
//
// Drains NPU inference results from a small ring held in an external
// dual-port memory. The NPU writes results through port A at wr_ptr_o; this
// block reads them back in order through port B and presents each result to
// the host on a valid/ready stream. Result and drop statistics are kept
// alongside. When the ring is full and another result arrives, the oldest
// unread slot is sacrificed (overwritten by the writer).
//
// Ports:
//   clk_i            clock, all state on rising edge
//   reset_i          asynchronous active-high reset, clears all state
//   result_valid_i   one-cycle pulse per result written to port A at wr_ptr_o
//   addr_b_o         port B read address (registered)
//   re_b_o           port B read enable, one-cycle pulse (registered)
//   dout_b_i         port B read data, valid the cycle after re_b_o is sampled
//   out_data_o       inference presented to the host
//   out_valid_o      out_data_o valid
//   out_ready_i      host accept; transfer when out_valid_o && out_ready_i
//   stats_clear_i    synchronous clear of result_cnt_o/overflow_cnt_o/overflow_o
//   wr_ptr_o         next slot the NPU writes (port A address)
//   result_cnt_o     results observed, wraps modulo 2^16
//   overflow_cnt_o   dropped results, saturates at 255
//   overflow_o       sticky drop flag since reset/clear
// ---------------------------------------------------------------------------
module inference_drain #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              result_valid_i,
    output logic [ADDR_W-1:0] addr_b_o,
    output logic              re_b_o,
    input  logic [DATA_W-1:0] dout_b_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    input  logic              stats_clear_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [15:0]       result_cnt_o,
    output logic [7:0]        overflow_cnt_o,
    output logic              overflow_o
);

    localparam int               DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  PEND_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  PEND_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t            state_q;
    logic              re_b_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   pending_q, pending_d;
    logic [15:0]       result_cnt_q, result_cnt_d;
    logic [7:0]        overflow_cnt_q, overflow_cnt_d;
    logic              overflow_q, overflow_d;

    logic              drop;
    logic              issue;

    // A result landing on a full ring overwrites the oldest unread slot.
    // The read issue is suppressed in that cycle so rd_ptr only moves once.
    assign drop  = result_valid_i && (pending_q == PEND_FULL);
    assign issue = (state_q == ST_IDLE) && (pending_q != '0) && !drop;

    // ---------------------------------------------------------------
    // Ring pointers, occupancy and statistics
    // ---------------------------------------------------------------
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        pending_d      = pending_q;
        result_cnt_d   = result_cnt_q;
        overflow_cnt_d = overflow_cnt_q;
        overflow_d     = overflow_q;

        if (result_valid_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        // issue and drop are mutually exclusive by construction
        if (issue || drop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // On a drop occupancy stays at DEPTH: one entry in, one entry lost.
        if (!drop) begin
            case ({result_valid_i, issue})
                2'b10:   pending_d = pending_q + PEND_ONE;
                2'b01:   pending_d = pending_q - PEND_ONE;
                default: pending_d = pending_q;
            endcase
        end

        // Clear takes priority over any event in the same cycle.
        if (stats_clear_i) begin
            result_cnt_d   = '0;
            overflow_cnt_d = '0;
            overflow_d     = 1'b0;
        end else begin
            if (result_valid_i) begin
                result_cnt_d = result_cnt_q + 16'd1;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (overflow_cnt_q != 8'hFF) begin
                    overflow_cnt_d = overflow_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pending_q      <= '0;
            result_cnt_q   <= '0;
            overflow_cnt_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            pending_q      <= pending_d;
            result_cnt_q   <= result_cnt_d;
            overflow_cnt_q <= overflow_cnt_d;
            overflow_q     <= overflow_d;
        end
    end

    // ---------------------------------------------------------------
    // Read / present FSM. Once an entry has been issued it is owned here
    // until the host takes it, so overflow can never touch it.
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            re_b_q      <= 1'b0;
            addr_b_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            re_b_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        re_b_q   <= 1'b1;
                        addr_b_q <= rd_ptr_q;
                        state_q  <= ST_READ;
                    end
                end
                ST_READ: begin
                    // memory samples re_b at the end of this cycle
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    out_data_q  <= dout_b_i;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr_b_o       = addr_b_q;
    assign re_b_o         = re_b_q;
    assign out_data_o     = out_data_q;
    assign out_valid_o    = out_valid_q;
    assign wr_ptr_o       = wr_ptr_q;
    assign result_cnt_o   = result_cnt_q;
    assign overflow_cnt_o = overflow_cnt_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_inference_drain.sv
// ---------------------------------------------------------------------------
// tb_inference_drain
//
// Directed testbench for inference_drain. Models the inference memory
// (port A write at wr_ptr_o, registered port B read), drives results and
// host backpressure, and compares outputs with hand-computed values.
// ---------------------------------------------------------------------------
module tb_inference_drain;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        result_valid_i = 1'b0;
    logic [1:0]  addr_b_o;
    logic        re_b_o;
    logic [3:0]  dout_b_i = '0;
    logic [3:0]  out_data_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic        stats_clear_i = 1'b0;
    logic [1:0]  wr_ptr_o;
    logic [15:0] result_cnt_o;
    logic [7:0]  overflow_cnt_o;
    logic        overflow_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    logic [3:0] wdata = '0;
    logic [3:0] mem [4];

    logic [3:0] got_q [$];
    logic [1:0] addr_q [$];
    int         hs_cyc_q [$];

    inference_drain #(.ADDR_W(2), .DATA_W(4)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .result_valid_i (result_valid_i),
        .addr_b_o       (addr_b_o),
        .re_b_o         (re_b_o),
        .dout_b_i       (dout_b_i),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .stats_clear_i  (stats_clear_i),
        .wr_ptr_o       (wr_ptr_o),
        .result_cnt_o   (result_cnt_o),
        .overflow_cnt_o (overflow_cnt_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    // Inference memory: port A write, port B registered read.
    always @(posedge clk_i) begin
        if (result_valid_i) mem[wr_ptr_o] <= wdata;
        if (re_b_o) dout_b_i <= mem[addr_b_o];
    end

    // Record handshakes and read issues mid-cycle, away from the clock edge.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (out_valid_o && out_ready_i) begin
                got_q.push_back(out_data_o);
                hs_cyc_q.push_back(cyc);
            end
            if (re_b_o) addr_q.push_back(addr_b_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        result_valid_i = 1'b1;
        wdata = v;
        step(1);
        result_valid_i = 1'b0;
    endtask

    task automatic clear_logs();
        got_q.delete();
        addr_q.delete();
        hs_cyc_q.delete();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        result_valid_i = 1'b0;
        out_ready_i = 1'b0;
        stats_clear_i = 1'b0;
        step(2);
        clear_logs();
        reset_i = 1'b0;
        step(1);
    endtask

    task automatic wait_hs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= n) break;
            step(1);
        end
        if (got_q.size() >= n) ok = 1'b1;
    endtask

    // -----------------------------------------------------------------
    task automatic test_reset();
        logic [34:0] packed_out;
        reset_i = 1'b1;
        step(2);
        packed_out = {addr_b_o, re_b_o, out_data_o, out_valid_o, wr_ptr_o,
                      result_cnt_o, overflow_cnt_o, overflow_o};
        vec_cnt++;
        if (packed_out !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h expected 0", packed_out);
        end
        reset_i = 1'b0;
        step(4);
        vec_cnt++;
        if ({out_valid_o, re_b_o} !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_idle: got valid/re %b expected 00", {out_valid_o, re_b_o});
        end
        $display("test_reset done");
    endtask

    // -----------------------------------------------------------------
    task automatic test_single();
        do_reset();
        pulse(4'h7);
        vec_cnt++;
        if ({result_cnt_o, wr_ptr_o, re_b_o} !== {16'd1, 2'd1, 1'b0}) begin
            err_cnt++;
            $display("FAIL single_edge1: got cnt=%0d wr=%0d re=%b expected 1 1 0",
                     result_cnt_o, wr_ptr_o, re_b_o);
        end
        step(1);
        vec_cnt++;
        if ({re_b_o, addr_b_o} !== {1'b1, 2'd0}) begin
            err_cnt++;
            $display("FAIL single_read: got re=%b addr=%0d expected 1 0", re_b_o, addr_b_o);
        end
        step(1);
        vec_cnt++;
        if ({re_b_o, out_valid_o} !== 2'b00) begin
            err_cnt++;
            $display("FAIL single_wait: got re=%b valid=%b expected 0 0", re_b_o, out_valid_o);
        end
        step(1);
        vec_cnt++;
        if ({out_valid_o, out_data_o} !== {1'b1, 4'h7}) begin
            err_cnt++;
            $display("FAIL single_present: got valid=%b data=%h expected 1 7",
                     out_valid_o, out_data_o);
        end
        out_ready_i = 1'b1;
        step(1);
        out_ready_i = 1'b0;
        vec_cnt++;
        if ({out_valid_o, out_data_o} !== {1'b0, 4'h7}) begin
            err_cnt++;
            $display("FAIL single_accept: got valid=%b data=%h expected 0 7",
                     out_valid_o, out_data_o);
        end
        step(4);
        vec_cnt++;
        if (addr_q.size() !== 1 || result_cnt_o !== 16'd1) begin
            err_cnt++;
            $display("FAIL single_after: got reads=%0d cnt=%0d expected 1 1",
                     addr_q.size(), result_cnt_o);
        end
        $display("test_single done");
    endtask

    // -----------------------------------------------------------------
    task automatic test_backpressure();
        logic [3:0] exp_d [3] = '{4'h1, 4'h2, 4'h3};
        bit ok;
        do_reset();
        pulse(4'h1);
        pulse(4'h2);
        pulse(4'h3);
        for (int i = 0; i < 20; i++) begin
            step(1);
            vec_cnt++;
            if ({out_valid_o, out_data_o} !== {1'b1, 4'h1}) begin
                err_cnt++;
                $display("FAIL bp_hold cycle %0d: got valid=%b data=%h expected 1 1",
                         i, out_valid_o, out_data_o);
            end
        end
        vec_cnt++;
        if (addr_q.size() !== 1) begin
            err_cnt++;
            $display("FAIL bp_reads_held: got %0d reads expected 1", addr_q.size());
        end
        out_ready_i = 1'b1;
        wait_hs(3, 40, ok);
        vec_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL bp_timeout: got %0d outputs expected 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vec_cnt++;
                if (got_q[i] !== exp_d[i] || addr_q[i] !== 2'(i)) begin
                    err_cnt++;
                    $display("FAIL bp_order %0d: got data=%h addr=%0d expected %h %0d",
                             i, got_q[i], addr_q[i], exp_d[i], i);
                end
            end
        end
        step(10);
        out_ready_i = 1'b0;
        vec_cnt++;
        if (addr_q.size() !== 3 || out_valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_empty: got reads=%0d valid=%b expected 3 0",
                     addr_q.size(), out_valid_o);
        end
        $display("test_backpressure done");
    endtask

    // -----------------------------------------------------------------
    task automatic test_overflow();
        logic [3:0] exp_d [5] = '{4'h9, 4'hB, 4'hC, 4'hD, 4'hE};
        logic [1:0] exp_a [5] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] v;
        bit ok;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            v = 4'h9 + 4'(i);
            pulse(v);
            if (i == 4) begin
                vec_cnt++;
                if (overflow_o !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL ovf_full_no_drop: got overflow=%b expected 0", overflow_o);
                end
            end
        end
        vec_cnt++;
        if ({overflow_cnt_o, overflow_o, result_cnt_o, wr_ptr_o} !==
            {8'd1, 1'b1, 16'd6, 2'd2}) begin
            err_cnt++;
            $display("FAIL ovf_stats: got ocnt=%0d ovf=%b cnt=%0d wr=%0d expected 1 1 6 2",
                     overflow_cnt_o, overflow_o, result_cnt_o, wr_ptr_o);
        end
        vec_cnt++;
        if ({out_valid_o, out_data_o} !== {1'b1, 4'h9}) begin
            err_cnt++;
            $display("FAIL ovf_hold: got valid=%b data=%h expected 1 9", out_valid_o, out_data_o);
        end
        out_ready_i = 1'b1;
        wait_hs(5, 60, ok);
        vec_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL ovf_timeout: got %0d outputs expected 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vec_cnt++;
                if (got_q[i] !== exp_d[i] || addr_q[i] !== exp_a[i]) begin
                    err_cnt++;
                    $display("FAIL ovf_order %0d: got data=%h addr=%0d expected %h %0d",
                             i, got_q[i], addr_q[i], exp_d[i], exp_a[i]);
                end
            end
        end
        out_ready_i = 1'b0;
        $display("test_overflow done");
    endtask

    // -----------------------------------------------------------------
    task automatic test_wrap();
        logic [3:0] v;
        bit ok;
        do_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = 4'(i + 3);
            pulse(v);
            step(4);
        end
        wait_hs(10, 20, ok);
        vec_cnt++;
        if (!ok || addr_q.size() !== 10) begin
            err_cnt++;
            $display("FAIL wrap_count: got outputs=%0d reads=%0d expected 10 10",
                     got_q.size(), addr_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vec_cnt++;
                if (addr_q[i] !== 2'(i % 4) || got_q[i] !== 4'(i + 3)) begin
                    err_cnt++;
                    $display("FAIL wrap_seq %0d: got addr=%0d data=%h expected %0d %h",
                             i, addr_q[i], got_q[i], i % 4, 4'(i + 3));
                end
            end
        end
        vec_cnt++;
        if ({overflow_o, overflow_cnt_o, wr_ptr_o, result_cnt_o} !==
            {1'b0, 8'd0, 2'd2, 16'd10}) begin
            err_cnt++;
            $display("FAIL wrap_stats: got ovf=%b ocnt=%0d wr=%0d cnt=%0d expected 0 0 2 10",
                     overflow_o, overflow_cnt_o, wr_ptr_o, result_cnt_o);
        end
        out_ready_i = 1'b0;
        $display("test_wrap done");
    endtask

    // -----------------------------------------------------------------
    task automatic test_back_to_back();
        logic [3:0] exp_d [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        bit ok;
        do_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) pulse(exp_d[i]);
        wait_hs(4, 40, ok);
        vec_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL b2b_timeout: got %0d outputs expected 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vec_cnt++;
                if (got_q[i] !== exp_d[i]) begin
                    err_cnt++;
                    $display("FAIL b2b_data %0d: got %h expected %h", i, got_q[i], exp_d[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                vec_cnt++;
                if (hs_cyc_q[i + 1] - hs_cyc_q[i] !== 4) begin
                    err_cnt++;
                    $display("FAIL b2b_spacing %0d: got %0d cycles expected 4",
                             i, hs_cyc_q[i + 1] - hs_cyc_q[i]);
                end
            end
        end
        out_ready_i = 1'b0;
        $display("test_back_to_back done");
    endtask

    // -----------------------------------------------------------------
    task automatic test_sat_clear();
        logic [3:0] exp_d [5] = '{4'h1, 4'hF, 4'h0, 4'h1, 4'h2};
        logic [3:0] v;
        bit ok;
        do_reset();
        for (int n = 1; n <= 305; n++) begin
            v = n[3:0];
            pulse(v);
            if (n == 259 || n == 260 || n == 305) begin
                vec_cnt++;
                if (overflow_cnt_o !== ((n == 259) ? 8'd254 : 8'd255)) begin
                    err_cnt++;
                    $display("FAIL sat_count n=%0d: got %0d expected %0d",
                             n, overflow_cnt_o, (n == 259) ? 254 : 255);
                end
            end
        end
        vec_cnt++;
        if ({result_cnt_o, overflow_o} !== {16'd305, 1'b1}) begin
            err_cnt++;
            $display("FAIL sat_stats: got cnt=%0d ovf=%b expected 305 1",
                     result_cnt_o, overflow_o);
        end
        // clear coincides with a result that also overflows
        result_valid_i = 1'b1;
        wdata = 4'h2;
        stats_clear_i = 1'b1;
        step(1);
        result_valid_i = 1'b0;
        stats_clear_i = 1'b0;
        vec_cnt++;
        if ({result_cnt_o, overflow_cnt_o, overflow_o, wr_ptr_o} !==
            {16'd0, 8'd0, 1'b0, 2'd2}) begin
            err_cnt++;
            $display("FAIL clear_stats: got cnt=%0d ocnt=%0d ovf=%b wr=%0d expected 0 0 0 2",
                     result_cnt_o, overflow_cnt_o, overflow_o, wr_ptr_o);
        end
        vec_cnt++;
        if ({out_valid_o, out_data_o} !== {1'b1, 4'h1}) begin
            err_cnt++;
            $display("FAIL clear_hold: got valid=%b data=%h expected 1 1", out_valid_o, out_data_o);
        end
        out_ready_i = 1'b1;
        wait_hs(5, 60, ok);
        step(8);
        vec_cnt++;
        if (!ok || got_q.size() !== 5) begin
            err_cnt++;
            $display("FAIL clear_drain_count: got %0d outputs expected 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vec_cnt++;
                if (got_q[i] !== exp_d[i]) begin
                    err_cnt++;
                    $display("FAIL clear_drain %0d: got %h expected %h", i, got_q[i], exp_d[i]);
                end
            end
        end
        vec_cnt++;
        if (result_cnt_o !== 16'd0) begin
            err_cnt++;
            $display("FAIL clear_after: got cnt=%0d expected 0", result_cnt_o);
        end
        out_ready_i = 1'b0;
        $display("test_sat_clear done");
    endtask

    // -----------------------------------------------------------------
    task automatic test_reset_mid_hold();
        logic [34:0] packed_out;
        bit ok;
        do_reset();
        pulse(4'h4);
        pulse(4'h5);
        pulse(4'h6);
        step(1);
        vec_cnt++;
        if ({out_valid_o, out_data_o} !== {1'b1, 4'h4}) begin
            err_cnt++;
            $display("FAIL rmh_hold: got valid=%b data=%h expected 1 4", out_valid_o, out_data_o);
        end
        #2;
        reset_i = 1'b1;
        #1;
        packed_out = {addr_b_o, re_b_o, out_data_o, out_valid_o, wr_ptr_o,
                      result_cnt_o, overflow_cnt_o, overflow_o};
        vec_cnt++;
        if (packed_out !== '0) begin
            err_cnt++;
            $display("FAIL rmh_async_clear: got %h expected 0", packed_out);
        end
        step(1);
        reset_i = 1'b0;
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            step(1);
            vec_cnt++;
            if ({out_valid_o, re_b_o} !== 2'b00) begin
                err_cnt++;
                $display("FAIL rmh_quiet cycle %0d: got valid/re %b expected 00",
                         i, {out_valid_o, re_b_o});
            end
        end
        out_ready_i = 1'b1;
        pulse(4'h8);
        wait_hs(1, 20, ok);
        vec_cnt++;
        if (!ok || got_q[0] !== 4'h8 || addr_q[0] !== 2'd0) begin
            err_cnt++;
            $display("FAIL rmh_restart: got n=%0d expected data 8 at addr 0", got_q.size());
        end
        out_ready_i = 1'b0;
        $display("test_reset_mid_hold done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_sat_clear();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/inference_drain.md
# inference_drain

Downstream consumer of the NPU inference memory. Tracks results written by the NPU pipeline into the 4-entry inference memory (port A), reads them back in order through memory port B, and presents each 4-bit inference to the host side on a valid/ready stream. Also keeps result and overflow statistics; when the host falls behind, the oldest unread entry is dropped.

## Interface
- ADDR_W, 2, inference memory address width; ring depth = 2^ADDR_W
- DATA_W, 4, inference result width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- result_valid  in  1  one-cycle pulse per NPU result written to port A; writer address mirrors internal wr_ptr
- addr_b  out  ADDR_W  memory port B read address, registered
- re_b  out  1  memory port B read enable, registered one-cycle pulse
- dout_b  in  DATA_W  memory port B read data, valid the cycle after the memory samples re_b
- out_data  out  DATA_W  inference presented to host
- out_valid  out  1  out_data valid
- out_ready  in  1  host accepts when out_valid && out_ready at a rising edge
- stats_clear  in  1  synchronous clear of result_cnt, overflow_cnt, overflow
- wr_ptr  out  ADDR_W  next memory slot the NPU writes; drive to port A address
- result_cnt  out  16  results observed, wraps modulo 2^16
- overflow_cnt  out  8  dropped results, saturates at 255
- overflow  out  1  sticky: at least one drop since reset/clear

## Operation
- Ring state: wr_ptr, rd_ptr (ADDR_W bits, wrap naturally), pending (0..2^ADDR_W) = unread entries still in memory.
- result_valid: wr_ptr++, result_cnt++, pending++ (subject to rules below).
- Read issue: leaving IDLE with pending>0 registers re_b=1, addr_b=rd_ptr; at the same edge rd_ptr++, pending-- (entry is now owned by the block).
- FSM:
  - IDLE: if pending>0 and not (pending==DEPTH and result_valid) -> READ.
  - READ: re_b=1 for this cycle only -> WAIT.
  - WAIT: dout_b valid this cycle; capture into out_data, set out_valid -> HOLD.
  - HOLD: out_valid held, out_data stable; on out_ready clear out_valid -> IDLE.
- Overflow: pending==DEPTH and result_valid at an edge -> oldest slot overwritten: rd_ptr++, pending stays DEPTH, overflow_cnt sat-increment, overflow=1; no read is issued that cycle.
- Simultaneous result_valid and read issue (pending<DEPTH): pending unchanged, both pointers advance.
- An entry already in READ/WAIT/HOLD is never dropped by overflow.
- stats_clear: clears counters and overflow; a result_valid in the same cycle is not counted; an overflow in the same cycle is also cleared (clear wins). Does not affect pointers, pending, or FSM.

## Timing
- Reset values: addr_b=0, re_b=0, out_data=0, out_valid=0, wr_ptr=0, result_cnt=0, overflow_cnt=0, overflow=0; internal rd_ptr=0, pending=0, state=IDLE.
- Reset mid-transfer: in-flight entry and all unread entries discarded; no out_valid after release until new result_valid.
- Latency, idle block: result_valid sampled at edge k -> re_b high after edge k+1 -> dout_b captured, out_valid high after edge k+3.
- Throughput: one result per 4 cycles with out_ready held high (READ, WAIT, HOLD, IDLE).
- out_valid never drops without handshake; out_data changes only on the capture edge.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Single result: reset, result_valid pulse at edge 1 -> re_b=1, addr_b=0 after edge 2; dout_b=4'h7 -> out_data=7, out_valid=1 after edge 4; out_ready=1 -> out_valid=0 next edge; result_cnt=1.
- Backpressure: 3 results 0x1,0x2,0x3 with out_ready=0 for 20 cycles -> out_data=1 held stable; then out_ready=1 -> outputs 1,2,3 in order, addr_b 0,1,2, pending returns to 0.
- Overflow: out_ready=0, 6 result_valid pulses -> first entry taken into HOLD, then 4 stored, 1 dropped: overflow_cnt=1, overflow=1, result_cnt=6; drained order skips the oldest stored entry.
- Wrap-around: 10 results with out_ready=1 spaced 5 cycles -> addr_b sequence 0,1,2,3,0,1,2,3,0,1, no overflow, wr_ptr=2.
- Saturation/clear: force 300 drops -> overflow_cnt=255; stats_clear pulse -> counters 0, overflow=0, pending unchanged.
- Reset mid-HOLD: assert reset while out_valid=1 with 2 pending -> all outputs 0 immediately; after release no out_valid without new result_valid.
